// File: rtl/frame_pkg.sv
// Geometry, address width and FSM encoding shared by the capture path, the
// framebuffer and the display readers.
package frame_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int WPL      = H_ACTIVE / 4;
  localparam int FB_WORDS = V_ACTIVE * WPL;
  localparam int ADDR_W   = 17;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    CAPTURE,
    DONE
  } cap_state_e;

  // Bit positions inside the sticky status word.
  localparam int ST_LINE_LONG   = 2;
  localparam int ST_FRAME_SHORT = 1;
  localparam int ST_FRAME_ABORT = 0;

endpackage

// File: rtl/fb_addr_gen.sv
// Row/column/line-base counters for the framebuffer; turns each accepted
// pixel word into one registered write one cycle later.
module fb_addr_gen
  import frame_pkg::ADDR_W;
#(
  parameter int WPL      = frame_pkg::WPL,
  parameter int V_ACTIVE = frame_pkg::V_ACTIVE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              capture,
  input  logic              pix_valid,
  input  logic [31:0]       pix_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              line_long,
  output logic              frame_full
);

  localparam int RW = $clog2(V_ACTIVE + 1);
  localparam int CW = $clog2(WPL + 1);

  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic [ADDR_W-1:0] line_base;
  logic              valid_q;
  logic              row_open;
  logic              col_open;
  logic              line_end;
  logic              take;

  assign row_open  = (row < RW'(V_ACTIVE));
  assign col_open  = (col < CW'(WPL));
  assign line_end  = capture && valid_q && !pix_valid;
  assign take      = capture && !clear && pix_valid && row_open && col_open;
  assign line_long = capture && pix_valid && row_open && !col_open;
  // A line closing in this very cycle counts toward completeness.
  assign frame_full = !row_open || (line_end && (row == RW'(V_ACTIVE - 1)));

  // NOTE: sequential state uses <= so every register samples pre-edge values
  // no matter how the statements below are ordered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      line_base <= '0;
      valid_q   <= 1'b0;
    end else if (clear) begin
      row       <= '0;
      col       <= '0;
      line_base <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= pix_valid;
      if (line_end) begin
        col <= '0;
        if (row_open) begin
          row       <= row + 1'b1;
          line_base <= line_base + ADDR_W'(WPL);
        end
      end else if (take) begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= take;
      if (take) begin
        wr_addr <= line_base + ADDR_W'(col);
        wr_data <= pix_data;
      end
    end
  end

endmodule

// File: rtl/frame_capture.sv
// Camera frame capture: frame-level FSM, ping-pong buffer select and sticky
// error status around the framebuffer address generator.
module frame_capture
  import frame_pkg::ADDR_W, frame_pkg::cap_state_e,
         frame_pkg::IDLE, frame_pkg::WAIT_SOF, frame_pkg::CAPTURE, frame_pkg::DONE,
         frame_pkg::ST_LINE_LONG, frame_pkg::ST_FRAME_SHORT, frame_pkg::ST_FRAME_ABORT;
#(
  parameter int H_ACTIVE = frame_pkg::H_ACTIVE,
  parameter int V_ACTIVE = frame_pkg::V_ACTIVE,
  parameter int WPL      = H_ACTIVE / 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic [31:0]       pix_data,
  input  logic              pix_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              wr_buf,
  output logic              rd_buf,
  output logic              frame_done,
  output logic [2:0]        status
);

  cap_state_e state;
  cap_state_e state_nxt;
  logic       restart;
  logic       end_frame;
  logic       abort;
  logic       frame_full;
  logic       line_long;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    end_frame = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (arm) state_nxt = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (!arm) begin
          state_nxt = IDLE;
        end else if (frame_start) begin
          state_nxt = CAPTURE;
          restart   = 1'b1;
        end
      end
      CAPTURE: begin
        if (frame_end) begin
          // Coincident start is an end followed by an immediate new frame.
          end_frame = 1'b1;
          if (frame_start && arm) restart   = 1'b1;
          else                    state_nxt = DONE;
        end else if (frame_start) begin
          abort   = 1'b1;
          restart = 1'b1;
        end
      end
      DONE: begin
        if (!arm) begin
          state_nxt = IDLE;
        end else if (frame_start) begin
          state_nxt = CAPTURE;
          restart   = 1'b1;
        end else begin
          state_nxt = WAIT_SOF;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  fb_addr_gen #(
    .WPL      (WPL),
    .V_ACTIVE (V_ACTIVE)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart),
    .capture    (state == CAPTURE),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .line_long  (line_long),
    .frame_full (frame_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_buf     <= 1'b0;
      frame_done <= 1'b0;
      status     <= '0;
    end else begin
      frame_done <= end_frame && frame_full;
      if (end_frame && frame_full) wr_buf <= ~wr_buf;
      if (line_long)               status[ST_LINE_LONG]   <= 1'b1;
      if (end_frame && !frame_full) status[ST_FRAME_SHORT] <= 1'b1;
      if (abort)                   status[ST_FRAME_ABORT] <= 1'b1;
    end
  end

  assign rd_buf = ~wr_buf;

endmodule

// File: tb/tb_frame_capture.sv
// Randomized bench for frame_capture on a reduced geometry, scored against a
// line/frame-level reference model of the framebuffer writes.
module tb_frame_capture;

  localparam int H     = 32;
  localparam int V     = 6;
  localparam int WPL_T = H / 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic [31:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_buf;
  logic        rd_buf;
  logic        frame_done;
  logic [2:0]  status;

  always #5 clk = ~clk;

  frame_capture #(
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_buf      (wr_buf),
    .rd_buf      (rd_buf),
    .frame_done  (frame_done),
    .status      (status)
  );

  typedef struct packed {
    logic [16:0] addr;
    logic [31:0] data;
    logic        half;
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  int  done_cnt = 0;
  int  tests = 0;
  int  fails = 0;
  int  g0, d0, exp_done;
  logic       exp_buf;
  logic [2:0] exp_status;
  bit  m_arm, m_active;
  int  m_row;

  // Monitor: everything written to the framebuffer, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) got_q.push_back('{addr: wr_addr, data: wr_data, half: wr_buf});
      if (frame_done) done_cnt++;
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; arm = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    pix_valid = 1'b0; pix_data = '0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    exp_q.delete();
    exp_buf = 1'b0; exp_status = '0; exp_done = 0;
    m_arm = 1'b0; m_active = 1'b0; m_row = 0;
    g0 = got_q.size(); d0 = done_cnt;
  endtask

  task automatic set_arm(bit a);
    arm = a; m_arm = a;
  endtask

  // Reference model of frame boundaries.
  task automatic model_end();
    if (m_active) begin
      if (m_row >= V) begin exp_buf = ~exp_buf; exp_done++; end
      else exp_status[1] = 1'b1;
      m_active = 1'b0;
    end
  endtask

  task automatic model_start();
    if (m_active) begin exp_status[0] = 1'b1; m_row = 0; end
    else if (m_arm) begin m_active = 1'b1; m_row = 0; end
  endtask

  task automatic pulse_start();
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    model_start();
  endtask

  task automatic pulse_end();
    frame_end = 1'b1; cyc(); frame_end = 1'b0;
    model_end();
    cyc();
  endtask

  // One line of n words; fe/fs ride on the cycle where pix_valid falls.
  task automatic send_line(int n, bit fe = 1'b0, bit fs = 1'b0);
    for (int k = 0; k < n; k++) begin
      pix_valid = 1'b1;
      pix_data  = $urandom;
      if (m_active && m_row < V && k < WPL_T)
        exp_q.push_back('{addr: 17'(m_row * WPL_T + k), data: pix_data, half: exp_buf});
      cyc();
    end
    if (m_active && m_row < V && n > WPL_T) exp_status[2] = 1'b1;
    pix_valid = 1'b0; frame_end = fe; frame_start = fs;
    cyc();
    frame_end = 1'b0; frame_start = 1'b0;
    if (m_active) m_row++;
    if (fe) model_end();
    if (fs) model_start();
    cyc($urandom_range(1, 3));
  endtask

  task automatic send_frame(int lines);
    pulse_start();
    for (int r = 0; r < lines; r++) send_line(WPL_T);
    pulse_end();
  endtask

  task automatic test_reset();
    #2;
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL reset wr_en: got %b want 0", wr_en); end
    tests++; if (wr_addr !== 17'd0) begin fails++; $display("FAIL reset wr_addr: got %0d want 0", wr_addr); end
    tests++; if (wr_data !== 32'd0) begin fails++; $display("FAIL reset wr_data: got %h want 0", wr_data); end
    tests++; if (wr_buf !== 1'b0) begin fails++; $display("FAIL reset wr_buf: got %b want 0", wr_buf); end
    tests++; if (rd_buf !== 1'b1) begin fails++; $display("FAIL reset rd_buf: got %b want 1", rd_buf); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset frame_done: got %b want 0", frame_done); end
    tests++; if (status !== 3'b000) begin fails++; $display("FAIL reset status: got %b want 000", status); end
    do_reset();
  endtask

  task automatic test_ignore_idle();
    do_reset();
    send_line(WPL_T);
    set_arm(1'b1); cyc(2);
    send_line(WPL_T);
    cyc(3);
    tests++;
    if (got_q.size() - g0 !== 0) begin
      fails++; $display("FAIL ignore_idle writes: got %0d want 0", got_q.size() - g0);
    end
  endtask

  task automatic test_full_frame();
    send_frame(V);
    cyc(3);
    tests++;
    if (got_q.size() - g0 !== exp_q.size()) begin
      fails++; $display("FAIL full_frame count: got %0d want %0d", got_q.size() - g0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      tests++;
      if (got_q[g0+i] !== exp_q[i]) begin
        fails++;
        $display("FAIL full_frame write %0d: got a=%0d d=%h b=%b want a=%0d d=%h b=%b", i,
                 got_q[g0+i].addr, got_q[g0+i].data, got_q[g0+i].half, exp_q[i].addr, exp_q[i].data, exp_q[i].half);
      end
    end
    tests++;
    if (got_q.size() == 0 || got_q[got_q.size()-1].addr !== 17'(V * WPL_T - 1)) begin
      fails++; $display("FAIL full_frame last_addr: got %0d want %0d",
                        got_q.size() == 0 ? -1 : int'(got_q[got_q.size()-1].addr), V * WPL_T - 1);
    end
    tests++; if (done_cnt - d0 !== exp_done) begin fails++; $display("FAIL full_frame done: got %0d want %0d", done_cnt - d0, exp_done); end
    tests++; if (wr_buf !== exp_buf) begin fails++; $display("FAIL full_frame wr_buf: got %b want %b", wr_buf, exp_buf); end
    tests++; if (rd_buf !== ~exp_buf) begin fails++; $display("FAIL full_frame rd_buf: got %b want %b", rd_buf, ~exp_buf); end
    tests++; if (status !== exp_status) begin fails++; $display("FAIL full_frame status: got %b want %b", status, exp_status); end
  endtask

  task automatic test_line_long();
    do_reset();
    set_arm(1'b1); cyc(2);
    pulse_start();
    for (int r = 0; r < V; r++) send_line(r == 2 ? WPL_T + 3 : WPL_T);
    pulse_end();
    cyc(3);
    tests++;
    if (got_q.size() - g0 !== exp_q.size()) begin
      fails++; $display("FAIL line_long count: got %0d want %0d", got_q.size() - g0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      tests++;
      if (got_q[g0+i] !== exp_q[i]) begin
        fails++;
        $display("FAIL line_long write %0d: got a=%0d d=%h b=%b want a=%0d d=%h b=%b", i,
                 got_q[g0+i].addr, got_q[g0+i].data, got_q[g0+i].half, exp_q[i].addr, exp_q[i].data, exp_q[i].half);
      end
    end
    tests++; if (status !== exp_status) begin fails++; $display("FAIL line_long status: got %b want %b", status, exp_status); end
    tests++; if (wr_buf !== exp_buf) begin fails++; $display("FAIL line_long wr_buf: got %b want %b", wr_buf, exp_buf); end
  endtask

  task automatic test_frame_short();
    do_reset();
    set_arm(1'b1); cyc(2);
    send_frame(V - 2);
    cyc(2);
    tests++; if (done_cnt - d0 !== exp_done) begin fails++; $display("FAIL short done: got %0d want %0d", done_cnt - d0, exp_done); end
    tests++; if (wr_buf !== exp_buf) begin fails++; $display("FAIL short wr_buf: got %b want %b", wr_buf, exp_buf); end
    tests++; if (status !== exp_status) begin fails++; $display("FAIL short status: got %b want %b", status, exp_status); end
    send_frame(V);
    cyc(3);
    tests++;
    if (got_q.size() - g0 !== exp_q.size()) begin
      fails++; $display("FAIL short count: got %0d want %0d", got_q.size() - g0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      tests++;
      if (got_q[g0+i] !== exp_q[i]) begin
        fails++;
        $display("FAIL short write %0d: got a=%0d d=%h b=%b want a=%0d d=%h b=%b", i,
                 got_q[g0+i].addr, got_q[g0+i].data, got_q[g0+i].half, exp_q[i].addr, exp_q[i].data, exp_q[i].half);
      end
    end
    tests++; if (done_cnt - d0 !== exp_done) begin fails++; $display("FAIL short_next done: got %0d want %0d", done_cnt - d0, exp_done); end
    tests++; if (wr_buf !== exp_buf) begin fails++; $display("FAIL short_next wr_buf: got %b want %b", wr_buf, exp_buf); end
  endtask

  task automatic test_abort();
    do_reset();
    set_arm(1'b1); cyc(2);
    pulse_start();
    for (int r = 0; r < 3; r++) send_line(WPL_T);
    pulse_start();
    for (int r = 0; r < V; r++) send_line(WPL_T);
    pulse_end();
    cyc(3);
    tests++;
    if (got_q.size() - g0 !== exp_q.size()) begin
      fails++; $display("FAIL abort count: got %0d want %0d", got_q.size() - g0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      tests++;
      if (got_q[g0+i] !== exp_q[i]) begin
        fails++;
        $display("FAIL abort write %0d: got a=%0d d=%h b=%b want a=%0d d=%h b=%b", i,
                 got_q[g0+i].addr, got_q[g0+i].data, got_q[g0+i].half, exp_q[i].addr, exp_q[i].data, exp_q[i].half);
      end
    end
    tests++; if (status !== exp_status) begin fails++; $display("FAIL abort status: got %b want %b", status, exp_status); end
    tests++; if (done_cnt - d0 !== exp_done) begin fails++; $display("FAIL abort done: got %0d want %0d", done_cnt - d0, exp_done); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_arm(1'b1); cyc(2);
    pulse_start();
    for (int r = 0; r < V - 1; r++) send_line(WPL_T);
    send_line(WPL_T, 1'b1, 1'b0);
    pulse_start();
    for (int r = 0; r < V - 1; r++) send_line(WPL_T);
    send_line(WPL_T, 1'b1, 1'b1);
    for (int r = 0; r < V; r++) send_line(WPL_T);
    pulse_end();
    cyc(3);
    tests++;
    if (got_q.size() - g0 !== exp_q.size()) begin
      fails++; $display("FAIL b2b count: got %0d want %0d", got_q.size() - g0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      tests++;
      if (got_q[g0+i] !== exp_q[i]) begin
        fails++;
        $display("FAIL b2b write %0d: got a=%0d d=%h b=%b want a=%0d d=%h b=%b", i,
                 got_q[g0+i].addr, got_q[g0+i].data, got_q[g0+i].half, exp_q[i].addr, exp_q[i].data, exp_q[i].half);
      end
    end
    tests++; if (done_cnt - d0 !== exp_done) begin fails++; $display("FAIL b2b done: got %0d want %0d", done_cnt - d0, exp_done); end
    tests++; if (wr_buf !== exp_buf) begin fails++; $display("FAIL b2b wr_buf: got %b want %b", wr_buf, exp_buf); end
    tests++; if (status !== exp_status) begin fails++; $display("FAIL b2b status: got %b want %b", status, exp_status); end
  endtask

  task automatic test_rst_midline();
    do_reset();
    set_arm(1'b1); cyc(2);
    pulse_start();
    for (int r = 0; r < 2; r++) send_line(WPL_T);
    // Fifth word's write is on the bus when reset hits, so only four get logged.
    for (int k = 0; k < 5; k++) begin
      pix_valid = 1'b1;
      pix_data  = $urandom;
      if (k < 4) exp_q.push_back('{addr: 17'(2 * WPL_T + k), data: pix_data, half: exp_buf});
      cyc();
    end
    tests++; if (wr_en !== 1'b1 || wr_addr !== 17'(2 * WPL_T + 4)) begin
      fails++; $display("FAIL midline pre_rst: got en=%b a=%0d want en=1 a=%0d", wr_en, wr_addr, 2 * WPL_T + 4);
    end
    #2 rst = 1'b1;
    #1;
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL midline wr_en: got %b want 0", wr_en); end
    tests++; if (wr_addr !== 17'd0) begin fails++; $display("FAIL midline wr_addr: got %0d want 0", wr_addr); end
    tests++; if (wr_data !== 32'd0) begin fails++; $display("FAIL midline wr_data: got %h want 0", wr_data); end
    tests++; if (wr_buf !== 1'b0 || rd_buf !== 1'b1) begin fails++; $display("FAIL midline bufs: got %b/%b want 0/1", wr_buf, rd_buf); end
    tests++; if (status !== 3'b000 || frame_done !== 1'b0) begin fails++; $display("FAIL midline status: got %b/%b want 000/0", status, frame_done); end
    tests++;
    if (got_q.size() - g0 !== exp_q.size()) begin
      fails++; $display("FAIL midline count: got %0d want %0d", got_q.size() - g0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      tests++;
      if (got_q[g0+i] !== exp_q[i]) begin
        fails++;
        $display("FAIL midline write %0d: got a=%0d d=%h want a=%0d d=%h", i,
                 got_q[g0+i].addr, got_q[g0+i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    do_reset();
    set_arm(1'b1); cyc(2);
    send_frame(V);
    cyc(3);
    tests++;
    if (got_q.size() - g0 !== exp_q.size()) begin
      fails++; $display("FAIL restart count: got %0d want %0d", got_q.size() - g0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      tests++;
      if (got_q[g0+i] !== exp_q[i]) begin
        fails++;
        $display("FAIL restart write %0d: got a=%0d d=%h b=%b want a=%0d d=%h b=%b", i,
                 got_q[g0+i].addr, got_q[g0+i].data, got_q[g0+i].half, exp_q[i].addr, exp_q[i].data, exp_q[i].half);
      end
    end
  endtask

  task automatic test_arm_drop();
    do_reset();
    set_arm(1'b1); cyc(2);
    send_frame(V);
    pulse_start();
    for (int r = 0; r < V; r++) begin
      if (r == V / 2) set_arm(1'b0);
      send_line(WPL_T);
    end
    pulse_end();
    cyc(2);
    tests++; if (dut.state !== frame_pkg::IDLE) begin fails++; $display("FAIL arm_drop state: got %0d want %0d", dut.state, frame_pkg::IDLE); end
    send_frame(V);
    cyc(3);
    tests++;
    if (got_q.size() - g0 !== exp_q.size()) begin
      fails++; $display("FAIL arm_drop count: got %0d want %0d", got_q.size() - g0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      tests++;
      if (got_q[g0+i] !== exp_q[i]) begin
        fails++;
        $display("FAIL arm_drop write %0d: got a=%0d d=%h b=%b want a=%0d d=%h b=%b", i,
                 got_q[g0+i].addr, got_q[g0+i].data, got_q[g0+i].half, exp_q[i].addr, exp_q[i].data, exp_q[i].half);
      end
    end
    tests++; if (done_cnt - d0 !== exp_done) begin fails++; $display("FAIL arm_drop done: got %0d want %0d", done_cnt - d0, exp_done); end
    tests++; if (wr_buf !== exp_buf) begin fails++; $display("FAIL arm_drop wr_buf: got %b want %b", wr_buf, exp_buf); end
  endtask

  initial begin
    test_reset();
    test_ignore_idle();
    test_full_frame();
    test_line_long();
    test_frame_short();
    test_abort();
    test_back_to_back();
    test_rst_midline();
    test_arm_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_capture.md
FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line kept.
REQ-002 Parameter V_ACTIVE, default 480: active lines per frame kept.
REQ-003 Parameter WPL, default H_ACTIVE/4: 32-bit words per kept line (four raw8 pixels per word, pixel 0 in [7:0]).
REQ-004 Clocking SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  pixel-side clock, the camera byte clock domain.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 arm  in  1  level; while high, frames are captured continuously; while low, capture stops at the next frame boundary.
REQ-008 frame_start  in  1  one-cycle start-of-frame pulse from the CSI receiver.
REQ-009 frame_end  in  1  one-cycle end-of-frame pulse.
REQ-010 pix_data  in  32  four packed raw8 pixels.
REQ-011 pix_valid  in  1  pix_data qualifier; a falling edge marks end of line.
REQ-012 wr_en  out  1  framebuffer write strobe.
REQ-013 wr_addr  out  17  framebuffer word address (0..V_ACTIVE*WPL-1).
REQ-014 wr_data  out  32  framebuffer write data.
REQ-015 wr_buf  out  1  ping-pong half currently being written.
REQ-016 rd_buf  out  1  completed half for display; always ~wr_buf.
REQ-017 frame_done  out  1  one-cycle pulse on a complete frame.
REQ-018 status  out  3  sticky {line_long, frame_short, frame_abort}.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT_SOF, CAPTURE, DONE.
REQ-020 IDLE->WAIT_SOF when arm=1; WAIT_SOF->CAPTURE on frame_start; CAPTURE->DONE on frame_end; DONE->WAIT_SOF (arm=1) or IDLE (arm=0) after one cycle.
REQ-021 pix_valid in IDLE or WAIT_SOF SHALL be ignored and produce no wr_en.
REQ-022 In CAPTURE, each pix_valid word with col<WPL and row<V_ACTIVE SHALL produce wr_en=1 exactly one cycle later, with wr_data=that word and wr_addr=row*WPL+col.
REQ-023 Address SHALL be formed incrementally (line_base+col, line_base += WPL per line); no multiplier.
REQ-024 col SHALL increment per accepted word and saturate at WPL; any further words in the line are dropped and set status[2].
REQ-025 A pix_valid falling edge in CAPTURE SHALL clear col and increment row; row saturates at V_ACTIVE, and lines beyond it are dropped silently.
REQ-026 On frame_end with row==V_ACTIVE: pulse frame_done, toggle wr_buf, in DONE.
REQ-027 On frame_end with row<V_ACTIVE: no toggle, no frame_done, set status[1].
REQ-028 frame_start in CAPTURE SHALL abort the frame: set status[0], reset row/col/line_base, stay in CAPTURE, no toggle.
REQ-029 frame_start and frame_end in the same cycle SHALL be treated as frame_end followed by the new frame_start (toggle if complete, then restart).
REQ-030 A pix_valid falling edge coincident with frame_end SHALL count that line before evaluating completeness.
REQ-031 Status bits SHALL clear only on rst.

Reset
REQ-032 rst SHALL, at any time including mid-frame, force state=IDLE, wr_en=0, wr_addr=0, wr_data=0, wr_buf=0, rd_buf=1, frame_done=0, status=0, and row=col=line_base=0.
REQ-033 The first write after rst SHALL be to wr_buf=0 at address 0.

Structure
REQ-034 Package frame_pkg SHALL hold H_ACTIVE, V_ACTIVE, WPL, FB_WORDS, ADDR_W=17 and the state enum; the buffer and display readers share it.
REQ-035 One sub-module is natural: fb_addr_gen (row/col/line_base counters, saturation, address output); the FSM and ping-pong stay in frame_capture.

Verification
REQ-036 arm=1, one 480-line frame of 160 words each -> 76800 writes, last wr_addr=76799, one frame_done, wr_buf 0->1, status=0.
REQ-037 Line of 170 words -> 160 writes for that line, next line base advances by 160, status=3'b100.
REQ-038 frame_end after 300 lines -> no frame_done, wr_buf unchanged, status=3'b010; the next full frame toggles normally.
REQ-039 frame_start at line 200 -> status=3'b001, next write at address 0, same wr_buf.
REQ-040 rst asserted mid-line (row 10, col 50) -> outputs at reset values within the same cycle; with arm=1, capture restarts cleanly from the next frame_start.
REQ-041 arm dropped during frame 2 -> frame 2 completes and toggles, state=IDLE, and frame 3 produces zero writes.
